mac_feeder: RTL and testbench

- Upstream sequencer for the `mac` stage of the MNIST inference engine.
- On `start`, it runs every neuron of one layer in turn. For each neuron it clears the MAC, streams N_IN pixel/weight pairs from synchronous-read memories into the MAC, waits for the pipeline to drain, then captures the accumulator result.
- Each captured result is presented with its neuron index to the downstream stage (activation/argmax).

---
 rtl/mac_feeder.sv | 156 +++++++++++++++
 tb/tb_mac_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_feeder.sv
// Layer sequencer feeding the mac stage: clear, stream N_IN pairs, drain, capture, per neuron.
// Optional MAC_FEEDER_RELU_EN: captured result is clamped to max(acc_in, 0).
module mac_feeder #(
   parameter int W        = 4,
   parameter int N_IN     = 784,
   parameter int N_NEURON = 10,
   parameter int XADDR_W  = 10,
   parameter int WADDR_W  = 13,
   parameter int IDX_W    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      rd_en,
   output logic [XADDR_W-1:0]        x_addr,
   output logic [WADDR_W-1:0]        w_addr,
   input  logic signed [W-1:0]       x_rdata,
   input  logic signed [W-1:0]       w_rdata,
   output logic                      mac_clr,
   output logic signed [W-1:0]       mac_x,
   output logic signed [W-1:0]       mac_c,
   input  logic signed [W-1:0]       acc_in,
   output logic                      out_valid,
   output logic [IDX_W-1:0]          out_idx,
   output logic signed [W-1:0]       out_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_CAPTURE, S_FINISH
   } state_t;

   localparam logic [XADDR_W-1:0] LAST_I    = XADDR_W'(N_IN - 1);
   localparam logic [IDX_W-1:0]   LAST_J    = IDX_W'(N_NEURON - 1);
   localparam logic [WADDR_W-1:0] BASE_STEP = WADDR_W'(N_IN);

   state_t                 state_reg, state_next;
   logic                   drain_reg, drain_next;
   logic [IDX_W-1:0]       j_reg, j_next;
   logic [WADDR_W-1:0]     base_reg, base_next;
   logic [XADDR_W-1:0]     x_addr_reg, x_addr_next;
   logic [WADDR_W-1:0]     w_addr_reg, w_addr_next;
   logic                   vld_reg;
   logic signed [W-1:0]    mac_x_reg, mac_c_reg;
   logic                   done_reg, out_valid_reg;
   logic [IDX_W-1:0]       out_idx_reg;
   logic signed [W-1:0]    out_data_reg;
   logic                   rd_en_c, mac_clr_c, capture_c;
   logic signed [W-1:0]    cap_val;

   always_comb begin
      state_next  = state_reg;
      drain_next  = drain_reg;
      j_next      = j_reg;
      base_next   = base_reg;
      x_addr_next = x_addr_reg;
      w_addr_next = w_addr_reg;
      rd_en_c     = 1'b0;
      mac_clr_c   = 1'b0;
      capture_c   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_CLEAR;
               j_next     = '0;
               base_next  = '0;
            end
         end
         S_CLEAR: begin
            mac_clr_c   = 1'b1;
            x_addr_next = '0;
            w_addr_next = base_reg;
            state_next  = S_STREAM;
         end
         S_STREAM: begin
            rd_en_c    = 1'b1;
            drain_next = 1'b0;
            // the last address is held so the memories see a stable bus while idle
            if (x_addr_reg == LAST_I) begin
               state_next = S_DRAIN;
            end else begin
               x_addr_next = x_addr_reg + 1'b1;
               w_addr_next = w_addr_reg + 1'b1;
            end
         end
         S_DRAIN: begin
            drain_next = ~drain_reg;
            if (drain_reg) state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            capture_c  = 1'b1;
            j_next     = j_reg + 1'b1;
            base_next  = base_reg + BASE_STEP;
            state_next = (j_reg == LAST_J) ? S_FINISH : S_CLEAR;
         end
         S_FINISH: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      cap_val = acc_in;
`ifdef MAC_FEEDER_RELU_EN
      if (acc_in[W-1]) cap_val = '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         drain_reg     <= 1'b0;
         j_reg         <= '0;
         base_reg      <= '0;
         x_addr_reg    <= '0;
         w_addr_reg    <= '0;
         vld_reg       <= 1'b0;
         mac_x_reg     <= '0;
         mac_c_reg     <= '0;
         done_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         out_idx_reg   <= '0;
         out_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         drain_reg     <= drain_next;
         j_reg         <= j_next;
         base_reg      <= base_next;
         x_addr_reg    <= x_addr_next;
         w_addr_reg    <= w_addr_next;
         vld_reg       <= rd_en_c;
         // zero operands on bubble cycles so the accumulator only sees real pairs
         mac_x_reg     <= vld_reg ? x_rdata : '0;
         mac_c_reg     <= vld_reg ? w_rdata : '0;
         done_reg      <= (state_reg == S_FINISH);
         out_valid_reg <= capture_c;
         if (capture_c) begin
            out_idx_reg  <= j_reg;
            out_data_reg <= cap_val;
         end
      end
   end

   assign busy      = (state_reg != S_IDLE);
   assign done      = done_reg;
   assign rd_en     = rd_en_c;
   assign x_addr    = x_addr_reg;
   assign w_addr    = w_addr_reg;
   assign mac_clr   = mac_clr_c;
   assign mac_x     = mac_x_reg;
   assign mac_c     = mac_c_reg;
   assign out_valid = out_valid_reg;
   assign out_idx   = out_idx_reg;
   assign out_data  = out_data_reg;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: two instances (1 and 2 neurons, N_IN=3) checked every cycle
// against a timeline model derived from the per-neuron schedule.
module tb_mac_feeder;

   localparam int N = 3;
   localparam int P = N + 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;

   logic              a_busy, a_done, a_rd_en, a_mac_clr, a_out_valid;
   logic [1:0]        a_x_addr;
   logic [2:0]        a_w_addr;
   logic signed [3:0] a_xr, a_wr, a_mac_x, a_mac_c, a_acc, a_out_data;
   logic [0:0]        a_out_idx;

   logic              b_busy, b_done, b_rd_en, b_mac_clr, b_out_valid;
   logic [1:0]        b_x_addr;
   logic [2:0]        b_w_addr;
   logic signed [3:0] b_xr, b_wr, b_mac_x, b_mac_c, b_acc, b_out_data;
   logic [0:0]        b_out_idx;

   logic signed [3:0] xmem [0:3];
   logic signed [3:0] wmem [0:7];

   int cyc, vectors, miscompares;
   int la [2];
   int hx [2], hw [2], hidx [2], hdata [2];

   always #5 clk = ~clk;

   mac_feeder #(.W(4), .N_IN(N), .N_NEURON(1), .XADDR_W(2), .WADDR_W(3), .IDX_W(1)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
      .rd_en(a_rd_en), .x_addr(a_x_addr), .w_addr(a_w_addr),
      .x_rdata(a_xr), .w_rdata(a_wr), .mac_clr(a_mac_clr),
      .mac_x(a_mac_x), .mac_c(a_mac_c), .acc_in(a_acc),
      .out_valid(a_out_valid), .out_idx(a_out_idx), .out_data(a_out_data));

   mac_feeder #(.W(4), .N_IN(N), .N_NEURON(2), .XADDR_W(2), .WADDR_W(3), .IDX_W(1)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
      .rd_en(b_rd_en), .x_addr(b_x_addr), .w_addr(b_w_addr),
      .x_rdata(b_xr), .w_rdata(b_wr), .mac_clr(b_mac_clr),
      .mac_x(b_mac_x), .mac_c(b_mac_c), .acc_in(b_acc),
      .out_valid(b_out_valid), .out_idx(b_out_idx), .out_data(b_out_data));

   // synchronous-read memories and behavioural MACs
   always @(posedge clk) begin
      if (a_rd_en) begin a_xr <= xmem[a_x_addr]; a_wr <= wmem[a_w_addr]; end
      if (b_rd_en) begin b_xr <= xmem[b_x_addr]; b_wr <= wmem[b_w_addr]; end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_acc <= '0;
         b_acc <= '0;
      end else begin
         a_acc <= a_mac_clr ? 4'sd0 : a_acc + a_mac_x * a_mac_c;
         b_acc <= b_mac_clr ? 4'sd0 : b_acc + b_mac_x * b_mac_c;
      end
   end

   function automatic int ref_out(input int j);
      int s;
      logic signed [3:0] r;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(xmem[i]) * int'(wmem[j*N+i]);
      r = s[3:0];
`ifdef MAC_FEEDER_RELU_EN
      if (r < 0) r = 4'sd0;
`endif
      return int'(r);
   endfunction

   function automatic bit mdl_busy(input int k, input int nn);
      return (k >= 1 && k <= P*nn + 1);
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_inst(input int id, input int nn, input string nm,
                             input logic busy, input logic done, input logic rd, input logic clr,
                             input int xa, input int wa, input int mx, input int mc,
                             input logic ov, input int idx, input int od);
      int k, r, j, emx, emc;
      bit e_rd, e_ov;
      k = cyc - la[id];
      e_rd = 1'b0; e_ov = 1'b0; emx = 0; emc = 0;
      if (k >= 2 && k - 2 < P*nn && (k - 2) % P < N) begin
         e_rd = 1'b1; r = (k - 2) % P; j = (k - 2) / P;
         hx[id] = r; hw[id] = j*N + r;
      end
      if (k >= 4 && k - 4 < P*nn && (k - 4) % P < N) begin
         r = (k - 4) % P; j = (k - 4) / P;
         emx = int'(xmem[r]); emc = int'(wmem[j*N + r]);
      end
      if (k >= 1 + P && k - 1 - P < P*nn && (k - 1 - P) % P == 0) begin
         e_ov = 1'b1; j = (k - 1 - P) / P;
         hidx[id] = j; hdata[id] = ref_out(j);
      end
      chk({nm, ".busy"}, int'(busy), int'(mdl_busy(k, nn)));
      chk({nm, ".done"}, int'(done), int'(k == P*nn + 2));
      chk({nm, ".rd_en"}, int'(rd), int'(e_rd));
      chk({nm, ".mac_clr"}, int'(clr), int'(k >= 1 && k - 1 < P*nn && (k - 1) % P == 0));
      chk({nm, ".x_addr"}, xa, hx[id]);
      chk({nm, ".w_addr"}, wa, hw[id]);
      chk({nm, ".mac_x"}, mx, emx);
      chk({nm, ".mac_c"}, mc, emc);
      chk({nm, ".out_valid"}, int'(ov), int'(e_ov));
      chk({nm, ".out_idx"}, idx, hidx[id]);
      chk({nm, ".out_data"}, od, hdata[id]);
   endtask

   task automatic check_both();
      check_inst(0, 1, "A", a_busy, a_done, a_rd_en, a_mac_clr, int'(a_x_addr), int'(a_w_addr),
                 int'(a_mac_x), int'(a_mac_c), a_out_valid, int'(a_out_idx), int'(a_out_data));
      check_inst(1, 2, "B", b_busy, b_done, b_rd_en, b_mac_clr, int'(b_x_addr), int'(b_w_addr),
                 int'(b_mac_x), int'(b_mac_c), b_out_valid, int'(b_out_idx), int'(b_out_data));
   endtask

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         la[n] = -1000; hx[n] = 0; hw[n] = 0; hidx[n] = 0; hdata[n] = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_both();
   endtask

   // start is only taken by an idle instance; anything else is ignored
   task automatic drive(input logic sa, input logic sb);
      start_a = sa;
      start_b = sb;
      if (sa && !mdl_busy(cyc - la[0], 1)) la[0] = cyc;
      if (sb && !mdl_busy(cyc - la[1], 2)) la[1] = cyc;
   endtask

   initial begin
      cyc = 0; vectors = 0; miscompares = 0;
      model_reset();
      xmem[0] = 4; xmem[1] = 6; xmem[2] = -4; xmem[3] = 0;
      wmem[0] = -3; wmem[1] = -1; wmem[2] = -3;
      wmem[3] = 1; wmem[4] = 1; wmem[5] = 1; wmem[6] = 0; wmem[7] = 0;

      tick(); tick();
      rst = 1'b0;
      tick();

      // directed layer: A -> -6 (or 0 clamped), B -> -6 then 6
      drive(1, 1); tick(); drive(0, 0);
      repeat (20) tick();

      // start held through the whole layer, dropped on the done cycle
      drive(1, 1);
      for (int t = 1; t <= 20; t++) begin
         tick();
         drive(t <= 8, t <= 15);
      end

      // stray start in DRAIN, then restart on the done cycle
      drive(1, 1);
      for (int t = 1; t <= 40; t++) begin
         tick();
         drive(t == 5 || t == 9, t == 5 || t == 16);
      end

      // reset in the middle of STREAM, then a clean rerun
      drive(1, 1); tick(); drive(0, 0);
      tick(); tick();
      rst = 1'b1;
      #1;
      model_reset();
      check_both();
      tick();
      rst = 1'b0;
      repeat (20) tick();
      drive(1, 1); tick(); drive(0, 0);
      repeat (20) tick();

      // random memory contents and random start pulses
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) xmem[i] = 4'($urandom_range(15));
         for (int i = 0; i < 8; i++) wmem[i] = 4'($urandom_range(15));
         for (int t = 0; t < 60; t++) begin
            tick();
            drive(t < 30 && $urandom_range(7) == 0, t < 30 && $urandom_range(7) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
